// File: rtl/scale_pkg.sv
// Shared encodings, step constants and request/config helpers for the
// frame-aligned scale-mode switch.
`timescale 1ns/1ps
package scale_pkg;

   typedef enum logic [1:0] {
      MODE_1X    = 2'd0,
      MODE_HALF  = 2'd1,
      MODE_ZOOM2 = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_BLANK   = 2'd2
   } state_e;

   // Source steps in unsigned 8.8 fixed point.
   localparam logic [15:0] STEP_1X    = 16'h0100;
   localparam logic [15:0] STEP_HALF  = 16'h0200;
   localparam logic [15:0] STEP_ZOOM2 = 16'h0080;

   typedef struct packed {
      logic  valid;
      mode_e mode;
   } req_t;

   function automatic req_t decode_req(input logic [2:0] en);
      req_t r;
      r = '{valid: 1'b0, mode: MODE_1X};
      case (en)
         3'b100:  r = '{valid: 1'b1, mode: MODE_1X};
         3'b010:  r = '{valid: 1'b1, mode: MODE_HALF};
         3'b001:  r = '{valid: 1'b1, mode: MODE_ZOOM2};
         default: r = '{valid: 1'b0, mode: MODE_1X};
      endcase
      return r;
   endfunction

   function automatic logic [15:0] step_of(input mode_e m);
      case (m)
         MODE_HALF:  return STEP_HALF;
         MODE_ZOOM2: return STEP_ZOOM2;
         default:    return STEP_1X;
      endcase
   endfunction

   // Half mode shrinks the output; 1:1 and centre-crop zoom keep source size.
   function automatic logic [11:0] dst_dim(input mode_e m, input logic [11:0] src);
      return (m == MODE_HALF) ? (src >> 1) : src;
   endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop synchronizer for the asynchronous input vsync plus a registered
// one-cycle rising-edge pulse (3 sys_clk edges from vs_in rise to vs_rise).
`timescale 1ns/1ps
module vs_edge_sync (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic vs_in,
   output logic vs_rise
);

   logic sync_1;
   logic sync_2;
   logic sync_2_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking would collapse
   // the synchronizer chain into a single stage.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_2_d <= 1'b0;
         vs_rise  <= 1'b0;
      end else begin
         sync_1   <= vs_in;
         sync_2   <= sync_1;
         sync_2_d <= sync_2;
         vs_rise  <= sync_2 & ~sync_2_d;
      end
   end

endmodule

// File: rtl/scale_mode_switch.sv
// Turns the one-hot scale request into scaler configuration applied only on
// an input vsync rising edge, then blanks the output for MUTE_FRAMES frames.
`timescale 1ns/1ps
module scale_mode_switch
   import scale_pkg::*;
#(
   parameter int SRC_W       = 1280,
   parameter int SRC_H       = 720,
   parameter int MUTE_FRAMES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [2:0]  change_en,
   input  logic        vs_in,
   output logic [1:0]  scale_sel,
   output logic [11:0] dst_width,
   output logic [11:0] dst_height,
   output logic [15:0] h_step,
   output logic [15:0] v_step,
   output logic        cfg_update,
   output logic        mute,
   output logic        busy
);

   localparam logic [11:0] SRC_W12    = 12'(SRC_W);
   localparam logic [11:0] SRC_H12    = 12'(SRC_H);
   localparam logic [3:0]  LAST_FRAME = 4'(MUTE_FRAMES - 1);

   logic vs_rise;

   vs_edge_sync u_vs_edge_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .vs_in     (vs_in),
      .vs_rise   (vs_rise)
   );

   state_e      state, state_nxt;
   mode_e       target, target_nxt;
   mode_e       last_req;
   mode_e       sel_q, sel_nxt;
   logic [3:0]  frame_cnt, frame_nxt;
   logic [11:0] width_nxt, height_nxt;
   logic [15:0] hstep_nxt, vstep_nxt;
   logic        update_nxt, mute_nxt;
   req_t        dec;
   mode_e       req_mode;

   // Invalid (non-one-hot) requests fall back to the last valid one.
   assign dec      = decode_req(change_en);
   assign req_mode = dec.valid ? dec.mode : last_req;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      frame_nxt  = frame_cnt;
      sel_nxt    = sel_q;
      width_nxt  = dst_width;
      height_nxt = dst_height;
      hstep_nxt  = h_step;
      vstep_nxt  = v_step;
      update_nxt = 1'b0;
      mute_nxt   = mute;

      case (state)
         ST_IDLE: begin
            if (req_mode != sel_q) begin
               target_nxt = req_mode;
               state_nxt  = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (req_mode == sel_q) begin
               state_nxt = ST_IDLE;
            end else begin
               // A request arriving with vs_rise wins over the older target.
               target_nxt = req_mode;
               if (vs_rise) begin
                  sel_nxt    = req_mode;
                  width_nxt  = dst_dim(req_mode, SRC_W12);
                  height_nxt = dst_dim(req_mode, SRC_H12);
                  hstep_nxt  = step_of(req_mode);
                  vstep_nxt  = step_of(req_mode);
                  update_nxt = 1'b1;
                  if (MUTE_FRAMES == 0) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     mute_nxt  = 1'b1;
                     frame_nxt = 4'd0;
                     state_nxt = ST_BLANK;
                  end
               end
            end
         end
         ST_BLANK: begin
            if (vs_rise) begin
               if (frame_cnt == LAST_FRAME) begin
                  mute_nxt  = 1'b0;
                  state_nxt = ST_IDLE;
               end else begin
                  frame_nxt = frame_cnt + 4'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         target     <= MODE_1X;
         last_req   <= MODE_1X;
         frame_cnt  <= 4'd0;
         sel_q      <= MODE_1X;
         dst_width  <= SRC_W12;
         dst_height <= SRC_H12;
         h_step     <= STEP_1X;
         v_step     <= STEP_1X;
         cfg_update <= 1'b0;
         mute       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         target     <= target_nxt;
         last_req   <= req_mode;
         frame_cnt  <= frame_nxt;
         sel_q      <= sel_nxt;
         dst_width  <= width_nxt;
         dst_height <= height_nxt;
         h_step     <= hstep_nxt;
         v_step     <= vstep_nxt;
         cfg_update <= update_nxt;
         mute       <= mute_nxt;
         busy       <= (state_nxt != ST_IDLE);
      end
   end

   assign scale_sel = sel_q;

endmodule

// File: tb/tb_scale_mode_switch.sv
// Scenario bench for scale_mode_switch: a scoreboard of expected configs is
// filled as switches are requested and drained on every cfg_update strobe.
`timescale 1ns/1ps
module tb_scale_mode_switch;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [2:0]  change_en;
   logic        vs_in;
   logic [1:0]  scale_sel;
   logic [11:0] dst_width;
   logic [11:0] dst_height;
   logic [15:0] h_step;
   logic [15:0] v_step;
   logic        cfg_update;
   logic        mute;
   logic        busy;

   typedef struct {
      logic [1:0]  sel;
      logic [11:0] w;
      logic [11:0] h;
      logic [15:0] hs;
      logic [15:0] vs;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   upd_cnt = 0;
   int   mute_cycles = 0;
   logic prev_upd = 1'b0;

   localparam exp_t EXP_1X    = '{2'd0, 12'd1280, 12'd720, 16'h0100, 16'h0100};
   localparam exp_t EXP_HALF  = '{2'd1, 12'd640,  12'd360, 16'h0200, 16'h0200};
   localparam exp_t EXP_ZOOM2 = '{2'd2, 12'd1280, 12'd720, 16'h0080, 16'h0080};

   scale_mode_switch #(.SRC_W(1280), .SRC_H(720), .MUTE_FRAMES(2)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .change_en  (change_en),
      .vs_in      (vs_in),
      .scale_sel  (scale_sel),
      .dst_width  (dst_width),
      .dst_height (dst_height),
      .h_step     (h_step),
      .v_step     (v_step),
      .cfg_update (cfg_update),
      .mute       (mute),
      .busy       (busy)
   );

   always #10 sys_clk = ~sys_clk;

   // Scoreboard monitor: every strobe must match the oldest queued config.
   always @(negedge sys_clk) begin
      exp_t e;
      if (mute) mute_cycles++;
      if (cfg_update) begin
         upd_cnt++;
         total++;
         if (prev_upd) begin
            bad++;
            $display("FAIL sb_strobe_width: cfg_update high two cycles in a row, required one");
         end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_update: strobe with sel=%0d, none expected", scale_sel);
         end else begin
            e = sb.pop_front();
            if ({scale_sel, dst_width, dst_height, h_step, v_step} !==
                {e.sel, e.w, e.h, e.hs, e.vs}) begin
               bad++;
               $display("FAIL sb_config: got sel=%0d %0dx%0d h=%h v=%h, expected sel=%0d %0dx%0d h=%h v=%h",
                        scale_sel, dst_width, dst_height, h_step, v_step,
                        e.sel, e.w, e.h, e.hs, e.vs);
            end
         end
      end
      prev_upd = cfg_update;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One vsync frame: m3/m4 = mute 3 and 4 cycles after the vs_in rise
   // (before and after the config edge), b4/b5 = busy at cycles 4 and 5.
   task automatic vs_frame(output logic m3, output logic m4,
                           output logic b4, output logic b5);
      @(negedge sys_clk) vs_in = 1'b1;
      repeat (3) @(negedge sys_clk);
      m3 = mute;
      @(negedge sys_clk);
      m4 = mute;
      b4 = busy;
      @(negedge sys_clk);
      b5 = busy;
      @(negedge sys_clk) vs_in = 1'b0;
      repeat (20) @(negedge sys_clk);
   endtask

   task automatic check_cfg(input string name, input exp_t e);
      total++;
      if ({scale_sel, dst_width, dst_height, h_step, v_step} !==
          {e.sel, e.w, e.h, e.hs, e.vs}) begin
         bad++;
         $display("FAIL %s: got sel=%0d %0dx%0d h=%h v=%h, expected sel=%0d %0dx%0d h=%h v=%h",
                  name, scale_sel, dst_width, dst_height, h_step, v_step,
                  e.sel, e.w, e.h, e.hs, e.vs);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic m3, m4, b4, b5;
      int   u0;
      sys_rst_n = 1'b0;
      change_en = 3'b100;
      vs_in     = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check_cfg("reset_cfg", EXP_1X);
      check_bit("reset_update", cfg_update, 1'b0);
      check_bit("reset_mute", mute, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      u0 = upd_cnt;
      mute_cycles = 0;
      repeat (3) vs_frame(m3, m4, b4, b5);
      total++;
      if (upd_cnt != u0 || mute_cycles != 0) begin
         bad++;
         $display("FAIL reset_quiet: got %0d updates %0d mute cycles, expected 0 and 0",
                  upd_cnt - u0, mute_cycles);
      end
   endtask

   task automatic test_invalid();
      logic m3, m4, b4, b5;
      int   u0;
      int   busy_seen;
      u0 = upd_cnt;
      busy_seen = 0;
      @(negedge sys_clk) change_en = 3'b011;
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         if (busy) busy_seen++;
      end
      vs_frame(m3, m4, b4, b5);
      total++;
      if (busy_seen != 0 || b4 !== 1'b0 || upd_cnt != u0) begin
         bad++;
         $display("FAIL invalid_ignored: got busy_cycles=%0d updates=%0d, expected 0 and 0",
                  busy_seen, upd_cnt - u0);
      end
      check_cfg("invalid_cfg", EXP_1X);
      change_en = 3'b100;
   endtask

   task automatic test_cancel();
      logic m3, m4, b4, b5;
      int   u0;
      u0 = upd_cnt;
      @(negedge sys_clk) change_en = 3'b010;
      @(negedge sys_clk);
      check_bit("cancel_busy_rise", busy, 1'b1);
      repeat (4) @(negedge sys_clk);
      change_en = 3'b100;
      @(negedge sys_clk);
      check_bit("cancel_busy_drop", busy, 1'b0);
      vs_frame(m3, m4, b4, b5);
      total++;
      if (upd_cnt != u0 || m4 !== 1'b0) begin
         bad++;
         $display("FAIL cancel_no_update: got %0d updates mute=%b, expected 0 updates mute=0",
                  upd_cnt - u0, m4);
      end
      check_cfg("cancel_cfg", EXP_1X);
   endtask

   task automatic test_switch_half();
      logic m3, m4, b4, b5;
      int   u0;
      u0 = upd_cnt;
      repeat (5) @(negedge sys_clk);
      change_en = 3'b010;
      sb.push_back(EXP_HALF);
      @(negedge sys_clk);
      check_bit("half_busy", busy, 1'b1);
      // Config must hold through the 3 edges before the config edge.
      @(negedge sys_clk) vs_in = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_cfg("half_hold", EXP_1X);
      @(negedge sys_clk);
      check_bit("half_strobe", cfg_update, 1'b1);
      check_bit("half_mute_rise", mute, 1'b1);
      @(negedge sys_clk);
      check_bit("half_strobe_fall", cfg_update, 1'b0);
      @(negedge sys_clk) vs_in = 1'b0;
      repeat (20) @(negedge sys_clk);
      vs_frame(m3, m4, b4, b5);
      check_bit("half_mute_frame1", m4, 1'b1);
      vs_frame(m3, m4, b4, b5);
      check_bit("half_mute_before_fall", m3, 1'b1);
      check_bit("half_mute_fall", m4, 1'b0);
      check_bit("half_busy_fall", b4, 1'b0);
      total++;
      if (upd_cnt != u0 + 1) begin
         bad++;
         $display("FAIL half_update_count: got %0d, expected 1", upd_cnt - u0);
      end
      check_cfg("half_cfg", EXP_HALF);
   endtask

   task automatic test_blank_request();
      logic m3, m4, b4, b5;
      change_en = 3'b100;
      sb.push_back(EXP_1X);
      vs_frame(m3, m4, b4, b5);
      check_bit("blank_mute_on", m4, 1'b1);
      change_en = 3'b001;
      repeat (3) @(negedge sys_clk);
      check_cfg("blank_req_held", EXP_1X);
      sb.push_back(EXP_ZOOM2);
      vs_frame(m3, m4, b4, b5);
      check_bit("blank_frame1_mute", m4, 1'b1);
      vs_frame(m3, m4, b4, b5);
      check_bit("blank_mute_fall", m4, 1'b0);
      check_bit("blank_idle_cycle", b4, 1'b0);
      check_bit("blank_then_pending", b5, 1'b1);
      check_cfg("blank_cfg_before_apply", EXP_1X);
      vs_frame(m3, m4, b4, b5);
      check_bit("zoom_mute_rise", m4, 1'b1);
      check_cfg("zoom_cfg", EXP_ZOOM2);
      vs_frame(m3, m4, b4, b5);
      vs_frame(m3, m4, b4, b5);
      check_bit("zoom_mute_fall", m4, 1'b0);
   endtask

   task automatic test_reset_pending();
      logic m3, m4, b4, b5;
      int   u0;
      @(negedge sys_clk) change_en = 3'b100;
      @(negedge sys_clk);
      check_bit("rst_pending_busy", busy, 1'b1);
      #3 sys_rst_n = 1'b0;
      #1;
      check_cfg("rst_async_cfg", EXP_1X);
      check_bit("rst_async_busy", busy, 1'b0);
      check_bit("rst_async_mute", mute, 1'b0);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      u0 = upd_cnt;
      repeat (3) @(negedge sys_clk);
      check_bit("rst_same_req_idle", busy, 1'b0);
      vs_frame(m3, m4, b4, b5);
      total++;
      if (upd_cnt != u0) begin
         bad++;
         $display("FAIL rst_no_update: got %0d updates, expected 0", upd_cnt - u0);
      end
      change_en = 3'b010;
      sb.push_back(EXP_HALF);
      @(negedge sys_clk);
      check_bit("rst_new_req_busy", busy, 1'b1);
      vs_frame(m3, m4, b4, b5);
      check_bit("rst_new_mute", m4, 1'b1);
      check_cfg("rst_new_cfg", EXP_HALF);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      change_en = 3'b100;
      vs_in     = 1'b0;
      test_reset();
      test_invalid();
      test_cancel();
      test_switch_half();
      test_blank_request();
      test_reset_pending();
      repeat (2) @(negedge sys_clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drained: got %0d pending entries, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scale_mode_switch.md
# scale_mode_switch

Consumes the one-hot scale-mode request produced by the touch-key controller and turns it into frame-aligned scaler configuration. A mode change is never applied mid-frame. The block waits for the next input-video vsync rising edge, loads the new geometry and step registers, pulses an update strobe, and then blanks the output for a programmable number of frames while the scaler line buffers refill. It sits between the key controller and the scaler datapath.

## Interface
- `SRC_W`, 1280: source active width in pixels (12-bit range).
- `SRC_H`, 720: source active height in lines (12-bit range).
- `MUTE_FRAMES`, 2: number of whole frames `mute` stays high after a switch; legal range 0..15.

Ports:
- `sys_clk` in 1: system clock, 50 MHz; the only clock.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `change_en` in 3: one-hot mode request, same clock domain; may change at any cycle.
- `vs_in` in 1: input vsync, active-high, asynchronous to `sys_clk`.
- `scale_sel` out 2: active mode; 0 = 1:1, 1 = half, 2 = 2x zoom.
- `dst_width` out 12: output active width.
- `dst_height` out 12: output active height.
- `h_step` out 16: horizontal source step, unsigned 8.8 fixed-point.
- `v_step` out 16: vertical source step, unsigned 8.8 fixed-point.
- `cfg_update` out 1: one-cycle strobe on the cycle the new config appears.
- `mute` out 1: scaler output is to be blanked.
- `busy` out 1: a switch is pending or blanking.

## Operation
- Request decode:
  - `3'b100` → mode 0, 1:1: dst = SRC_W × SRC_H, steps 16'h0100.
  - `3'b010` → mode 1, half: dst = SRC_W>>1 × SRC_H>>1, steps 16'h0200.
  - `3'b001` → mode 2, 2x zoom centre-crop: dst = SRC_W × SRC_H, steps 16'h0080.
  - Any non-one-hot value is an invalid request and is ignored; the last valid request is retained.
- Vsync path: 2-flop synchronizer on `vs_in`, then a registered rising-edge detect giving `vs_rise`, one cycle wide.
- FSM states:
  - IDLE: if the valid request ≠ `scale_sel`, latch `target` ← request and go to PENDING.
  - PENDING: track requests every cycle.
    - A new valid request ≠ `scale_sel` overwrites `target`.
    - A request equal to `scale_sel` cancels the switch: go to IDLE, no strobe, no mute.
    - On `vs_rise`: load all config outputs from `target` and pulse `cfg_update`.
      - If MUTE_FRAMES = 0, go to IDLE.
      - Otherwise set `mute` = 1, set `frame_cnt` = 0, and go to BLANK.
  - BLANK: each `vs_rise` increments `frame_cnt`.
    - When `frame_cnt` reaches MUTE_FRAMES−1 and `vs_rise` occurs, clear `mute` and go to IDLE.
    - Requests are not sampled in BLANK; they are evaluated on the first IDLE cycle.
- `busy` = (state ≠ IDLE).
- Reset values: FSM = IDLE, `scale_sel` = 0, `dst_width` = SRC_W, `dst_height` = SRC_H, `h_step` = `v_step` = 16'h0100, `cfg_update` = 0, `mute` = 0, `busy` = 0, `target` = 0, `frame_cnt` = 0, synchronizer flops = 0.
- Reset mid-switch (PENDING or BLANK) returns to the reset values immediately; no strobe is issued.

## Timing
- All outputs are registered.
- `change_en` edge → PENDING, with `busy` high, on the next clock.
- `vs_in` rising edge → `vs_rise` after 3 `sys_clk` edges (2 synchronizer + 1 edge register). Config outputs and `cfg_update` update on the cycle after `vs_rise`.
- `cfg_update` is high for exactly one cycle per applied switch and never when a switch is cancelled.
- Simultaneous request change and `vs_rise` in PENDING: the new request is applied if valid and ≠ `scale_sel`; if it equals `scale_sel`, the switch is cancelled.
- `mute` rises together with `cfg_update` and falls on the cycle after the MUTE_FRAMES-th following `vs_rise`.

## Structure
- Package `scale_pkg` holds:
  - Mode encodings: `MODE_1X` = 0, `MODE_HALF` = 1, `MODE_ZOOM2` = 2.
  - Step constants: `STEP_1X`, `STEP_HALF`, `STEP_ZOOM2`.
  - FSM state encoding.
- One sub-module, `vs_edge_sync`: 2-flop synchronizer plus rising-edge pulse.
- The FSM, mode decode and config registers stay in the top module.

## Test plan
- Reset release with `change_en` = 100: `scale_sel` = 0, 1280×720, steps 0x0100; no `cfg_update` and no `mute` for 3 frames.
- `change_en` 100→010 mid-frame: `busy` next cycle; config unchanged until 4 cycles after the `vs_in` rise, then `scale_sel` = 1, 640×360, steps 0x0200, one `cfg_update` pulse, `mute` high for exactly 2 frames.
- `change_en` 100→010→100 within one frame: `busy` drops at cancel; no `cfg_update`; config unchanged.
- `change_en` = 011 (invalid) while mode 0: no state change; `busy` stays 0.
- `change_en` 001 requested during BLANK of a previous switch: no action until `mute` falls, then PENDING; applied at the next vsync with `h_step` = 0x0080.
- `sys_rst_n` pulsed low while PENDING: all outputs return to reset values asynchronously; after release, a valid differing request is needed to start a new switch.
